// File: rtl/wb_skid_stage_pkg.sv
// Shared types and default widths for the write-back skid stage.
package pipe_pkg;

  localparam int unsigned REG_LEN      = 32;
  localparam int unsigned REG_ADDR_LEN = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [REG_LEN-1:0]      data;
    logic [REG_ADDR_LEN-1:0] addr;
    logic                    enable;
  } wb_payload_t;

endpackage

// File: rtl/wb_skid_stage_if.sv
// Handshake and payload bundle between MEM and the WB skid stage.
// Optional forwarding outputs appear when WB_SKID_FWD_EN is defined.
interface wb_skid_stage_if #(
  parameter int unsigned DATA_W = pipe_pkg::REG_LEN,
  parameter int unsigned ADDR_W = pipe_pkg::REG_ADDR_LEN
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_rd_data;
  logic [ADDR_W-1:0] in_rd_addr;
  logic              in_rd_enable;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rd_data;
  logic [ADDR_W-1:0] out_rd_addr;
  logic              out_rd_enable;
`ifdef WB_SKID_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_rd_addr;
  logic [DATA_W-1:0] fwd_rd_data;
`endif

  // Stage side
  modport slave (
    input  in_valid, in_rd_data, in_rd_addr, in_rd_enable, flush, out_ready,
    output in_ready, out_valid, out_rd_data, out_rd_addr, out_rd_enable
`ifdef WB_SKID_FWD_EN
    , output fwd_valid, fwd_rd_addr, fwd_rd_data
`endif
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_rd_data, in_rd_addr, in_rd_enable, flush, out_ready,
    input  in_ready, out_valid, out_rd_data, out_rd_addr, out_rd_enable
`ifdef WB_SKID_FWD_EN
    , input fwd_valid, fwd_rd_addr, fwd_rd_data
`endif
  );

endinterface

// File: rtl/wb_slot.sv
// One write-back payload register with load, clear and x0 write suppression.
// The stored enable is also dropped whenever the entry goes invalid, so the
// enable output is already gated by entry validity.
module wb_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W        = REG_LEN,
  parameter int unsigned ADDR_W        = REG_ADDR_LEN,
  parameter int unsigned ZERO_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_en,
  output logic [DATA_W-1:0] q_data,
  output logic [ADDR_W-1:0] q_addr,
  output logic              q_en
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;

  // Next payload: clear wins, else load with x0 suppression, else hold
  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    en_d   = en_q;
    if (clear) begin
      data_d = '0;
      addr_d = '0;
      en_d   = 1'b0;
    end else begin
      if (load) begin
        data_d = in_data;
        addr_d = in_addr;
        en_d   = in_en & ~((ZERO_SUPPRESS != 0) && (in_addr == '0));
      end
      if (!valid_d) en_d = 1'b0;
    end
  end

  // Payload register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      addr_q <= '0;
      en_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
      en_q   <= en_d;
    end
  end

  assign q_data = data_q;
  assign q_addr = addr_q;
  assign q_en   = en_q;

endmodule

// File: rtl/wb_skid_stage.sv
// Two-entry (main + skid) valid/ready stage for the MEM->WB write-back payload.
// Optional feature macro: WB_SKID_FWD_EN adds youngest-entry forwarding outputs.
module wb_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W        = REG_LEN,
  parameter int unsigned ADDR_W        = REG_ADDR_LEN,
  parameter int unsigned ZERO_SUPPRESS = 1
) (
  input  logic            clk,
  input  logic            rst,
  wb_skid_stage_if.slave  bus
);

  skid_state_t state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        in_fire, out_fire;
  logic        load_main, load_skid, main_from_skid, clear;

  logic [DATA_W-1:0] main_data, skid_data, main_src_data;
  logic [ADDR_W-1:0] main_addr, skid_addr, main_src_addr;
  logic              main_en, skid_en, main_src_en;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Next state and entry load controls; flush overrides everything
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    clear          = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
      clear   = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = BUSY;
            load_main = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = BUSY;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State and registered handshake flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Main entry source: skid when draining FULL, otherwise the incoming payload
  always_comb begin
    main_src_data = bus.in_rd_data;
    main_src_addr = bus.in_rd_addr;
    main_src_en   = bus.in_rd_enable;
    if (main_from_skid) begin
      main_src_data = skid_data;
      main_src_addr = skid_addr;
      main_src_en   = skid_en;
    end
  end

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_SUPPRESS(ZERO_SUPPRESS)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (load_main),
    .clear   (clear),
    .valid_d (out_valid_d),
    .in_data (main_src_data),
    .in_addr (main_src_addr),
    .in_en   (main_src_en),
    .q_data  (main_data),
    .q_addr  (main_addr),
    .q_en    (main_en)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_SUPPRESS(ZERO_SUPPRESS)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (load_skid),
    .clear   (clear),
    .valid_d (state_d == FULL),
    .in_data (bus.in_rd_data),
    .in_addr (bus.in_rd_addr),
    .in_en   (bus.in_rd_enable),
    .q_data  (skid_data),
    .q_addr  (skid_addr),
    .q_en    (skid_en)
  );

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rd_data   = main_data;
  assign bus.out_rd_addr   = main_addr;
  assign bus.out_rd_enable = main_en;

`ifdef WB_SKID_FWD_EN
  // Forward the youngest held entry that will write the register file
  always_comb begin
    bus.fwd_valid   = 1'b0;
    bus.fwd_rd_addr = '0;
    bus.fwd_rd_data = '0;
    if ((state_q == FULL) && skid_en) begin
      bus.fwd_valid   = 1'b1;
      bus.fwd_rd_addr = skid_addr;
      bus.fwd_rd_data = skid_data;
    end else if (out_valid_q && main_en) begin
      bus.fwd_valid   = 1'b1;
      bus.fwd_rd_addr = main_addr;
      bus.fwd_rd_data = main_data;
    end
  end
`endif

endmodule

// File: tb/tb_wb_skid_stage.sv
// Bench for wb_skid_stage: directed scenarios plus random traffic against a
// queue-based model of the held entries (oldest first).
module tb_wb_skid_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  wb_payload_t mq[$];
  wb_payload_t shadow;

  wb_skid_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_skid_stage #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk_eq("in_ready",  32'(bus.in_ready),      32'(mq.size() < 2));
    chk_eq("out_valid", 32'(bus.out_valid),     32'(mq.size() > 0));
    chk_eq("out_en",    32'(bus.out_rd_enable), 32'((mq.size() > 0) && shadow.enable));
    chk_eq("out_data",  bus.out_rd_data,        shadow.data);
    chk_eq("out_addr",  32'(bus.out_rd_addr),   32'(shadow.addr));
`ifdef WB_SKID_FWD_EN
    begin
      logic fv;
      wb_payload_t fp;
      fv = 1'b0;
      fp = '0;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].enable) begin
          fv = 1'b1;
          fp = mq[i];
        end
      end
      chk_eq("fwd_valid", 32'(bus.fwd_valid), 32'(fv));
      if (fv) begin
        chk_eq("fwd_addr", 32'(bus.fwd_rd_addr), 32'(fp.addr));
        chk_eq("fwd_data", bus.fwd_rd_data, fp.data);
      end
    end
`endif
  endtask

  // Drive one cycle of inputs, update the model at the edge, check at negedge
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] a,
                      input logic e, input logic fl, input logic ordy);
    logic inf, outf;
    wb_payload_t p;
    bus.in_valid     = v;
    bus.in_rd_data   = d;
    bus.in_rd_addr   = a;
    bus.in_rd_enable = e;
    bus.flush        = fl;
    bus.out_ready    = ordy;
    inf  = v && (mq.size() < 2);
    outf = ordy && (mq.size() > 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      shadow = '0;
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) begin
        p.data   = d;
        p.addr   = a;
        p.enable = e && (a != 5'd0);
        mq.push_back(p);
      end
      if (mq.size() > 0) shadow = mq[0];
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_rd_data   = '0;
    bus.in_rd_addr   = '0;
    bus.in_rd_enable = 1'b0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
    shadow           = '0;

    // Reset values
    @(negedge clk);
    chk_eq("rst_in_ready",  32'(bus.in_ready),      32'd1);
    chk_eq("rst_out_valid", 32'(bus.out_valid),     32'd0);
    chk_eq("rst_out_en",    32'(bus.out_rd_enable), 32'd0);
    chk_eq("rst_out_data",  bus.out_rd_data,        32'd0);
    chk_eq("rst_out_addr",  32'(bus.out_rd_addr),   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single transfer, one-cycle latency
    step(1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 1'b1);
    chk_eq("t1_data",  bus.out_rd_data,        32'hDEADBEEF);
    chk_eq("t1_addr",  32'(bus.out_rd_addr),   32'd5);
    chk_eq("t1_en",    32'(bus.out_rd_enable), 32'd1);
    chk_eq("t1_ready", 32'(bus.in_ready),      32'd1);
    idle(1'b1);

    // Back-pressure: fill both entries, then drain in order
    step(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0);
    chk_eq("full_ready", 32'(bus.in_ready),    32'd0);
    chk_eq("full_head",  bus.out_rd_data,      32'h11);
    step(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0);
    chk_eq("full_hold",  bus.out_rd_data,      32'h11);
    idle(1'b1);
    chk_eq("drain_b",    bus.out_rd_data,      32'h22);
    chk_eq("drain_rdy",  32'(bus.in_ready),    32'd1);
    idle(1'b1);
    chk_eq("drain_empty", 32'(bus.out_valid),  32'd0);

    // Write to x0 is held but not enabled
    step(1'b1, 32'h55, 5'd0, 1'b1, 1'b0, 1'b1);
    chk_eq("x0_valid", 32'(bus.out_valid),     32'd1);
    chk_eq("x0_en",    32'(bus.out_rd_enable), 32'd0);
    idle(1'b1);

    // Flush while FULL with an incoming payload
    step(1'b1, 32'h66, 5'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h77, 5'd7, 1'b1, 1'b0, 1'b0);
    chk_eq("pre_flush_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 32'h88, 5'd8, 1'b1, 1'b1, 1'b0);
    chk_eq("flush_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("flush_ready", 32'(bus.in_ready),  32'd1);
    chk_eq("flush_data",  bus.out_rd_data,    32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

`ifdef WB_SKID_FWD_EN
    step(1'b1, 32'hA, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hB, 5'd7, 1'b1, 1'b0, 1'b0);
    chk_eq("fwd_full_addr", 32'(bus.fwd_rd_addr), 32'd7);
    chk_eq("fwd_full_data", bus.fwd_rd_data,      32'hB);
    idle(1'b1);
    idle(1'b1);
`endif

    // Asynchronous reset between edges while holding a payload
    step(1'b1, 32'h99, 5'd9, 1'b1, 1'b0, 1'b0);
    chk_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_eq("arst_valid", 32'(bus.out_valid),     32'd0);
    chk_eq("arst_ready", 32'(bus.in_ready),      32'd1);
    chk_eq("arst_en",    32'(bus.out_rd_enable), 32'd0);
    chk_eq("arst_data",  bus.out_rd_data,        32'd0);
    chk_eq("arst_addr",  32'(bus.out_rd_addr),   32'd0);
    mq.delete();
    shadow = '0;
    @(negedge clk);
    rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           1'($urandom),
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
